// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS main control FSM. Inputs are opcode, zero and mem_ready. Outputs are the datapath selects and strobes, illegal_op, state_o and a retired-instruction count.
package MIPS_pkg;
  typedef logic [31:0] mips_data_t;
endpackage

module mips_multicycle_ctrl #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    iord,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_src,
  output logic                    pc_en,
  output logic                    illegal_op,
  output logic [STATE_WIDTH-1:0]  state_o,
  output MIPS_pkg::mips_data_t    instr_count
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);
  state_t state, next;
  MIPS_pkg::mips_data_t cnt;
  logic retire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= next;
  always_comb begin
    next = FETCH;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_src = 2'b00;
    pc_en = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_en = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
               opcode == OP_R    ? EXECUTE :
               opcode == OP_BEQ  ? BRANCH :
               opcode == OP_ADDI ? ADDIEX :
               opcode == OP_J    ? JUMP : FETCH;
        illegal_op = next == FETCH;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next = opcode == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        mem_read = 1'b1;
        next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mem_write = 1'b1;
        next = mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op = 2'b10;
        next = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 2'b01;
        pc_src = 2'b01;
        pc_en = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src = 2'b10;
        pc_en = 1'b1;
      end
      default: next = FETCH;
    endcase
    // reset is asynchronous, so strobes are masked combinationally for the whole reset window
    if (!rst_n) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      pc_en = 1'b0;
      illegal_op = 1'b0;
    end
  end
  assign retire = state == MEMWB || state == ALUWB || state == ADDIWB || state == BRANCH ||
                  state == JUMP || (state == MEMWR && mem_ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (retire) cnt <= cnt + 32'd1;
  assign instr_count = cnt;
  assign state_o = STATE_WIDTH'(state);
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: checks the controller against per-instruction state traces derived from opcode and memory wait counts
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;
  MIPS_pkg::mips_data_t instr_count;
  int tests = 0, fails = 0;
  logic [31:0] exp_cnt = 0;
  typedef struct { int st; bit rdy; } step_t;
  step_t plan[$];

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .state_o(state_o), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  wire [16:0] ctrl = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                      alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op};

  // expected control word per state, straight from the state descriptions
  function automatic logic [16:0] exp_ctrl(int st, bit r, bit z, bit ill);
    case (st)
      0:  return {1'b0, 1'b1, 1'b0, r,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, r,    1'b0};
      1:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, ill};
      2:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      3:  return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      4:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      5:  return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      6:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
      7:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      8:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, z,    1'b0};
      9:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      10: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      11: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
      default: return 17'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic add(input int st, input int waits);
    for (int i = 0; i < waits; i++) plan.push_back('{st, 1'b0});
    plan.push_back('{st, 1'b1});
  endtask

  // build the whole-instruction trace, then play it cycle by cycle
  task automatic run(input logic [5:0] op, input int wf, input int wm, input bit z);
    bit ill, ret;
    plan.delete();
    add(0, wf);
    plan.push_back('{1, 1'($urandom)});
    ill = 0;
    ret = 1;
    case (op)
      6'b100011: begin plan.push_back('{2, 1'($urandom)}); add(3, wm); plan.push_back('{4, 1'($urandom)}); end
      6'b101011: begin plan.push_back('{2, 1'($urandom)}); add(5, wm); end
      6'b000000: begin plan.push_back('{6, 1'($urandom)}); plan.push_back('{7, 1'($urandom)}); end
      6'b001000: begin plan.push_back('{9, 1'($urandom)}); plan.push_back('{10, 1'($urandom)}); end
      6'b000100: plan.push_back('{8, 1'($urandom)});
      6'b000010: plan.push_back('{11, 1'($urandom)});
      default: begin ill = 1; ret = 0; end
    endcase
    foreach (plan[k]) begin
      @(negedge clk);
      opcode = op;
      zero = z;
      mem_ready = plan[k].rdy;
      #1;
      chk($sformatf("state op=%b k=%0d", op, k), 32'(state_o), 32'(plan[k].st));
      chk($sformatf("ctrl op=%b st=%0d", op, plan[k].st), 32'(ctrl), 32'(exp_ctrl(plan[k].st, plan[k].rdy, z, ill)));
      chk($sformatf("count op=%b k=%0d", op, k), instr_count, exp_cnt);
    end
    if (ret) exp_cnt++;
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    #12;
    chk("reset strobes", 32'({mem_read, mem_write, ir_write, reg_write, pc_en, illegal_op}), 32'h0);
    chk("reset state", 32'(state_o), 32'd0);
    chk("reset count", instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(6'b100011, 0, 0, 0);
    run(6'b101011, 0, 3, 0);
    run(6'b000100, 0, 0, 1);
    run(6'b000100, 0, 0, 0);
    run(6'b111111, 0, 0, 0);
    run(6'b000000, 2, 0, 0);
    run(6'b001000, 0, 0, 0);
    run(6'b100011, 1, 2, 1);
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt;
    exp_cnt = 32'hFFFF_FFFF;
    run(6'b000010, 0, 0, 0);
    chk("wrap", exp_cnt, 32'd0);
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      run(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    @(negedge clk);
    opcode = 6'b000000;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("pre-reset aluwb", 32'(state_o), 32'd7);
    chk("pre-reset reg_write", 32'(reg_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort reg_write", 32'(reg_write), 32'd0);
    chk("abort state", 32'(state_o), 32'd0);
    chk("abort count", instr_count, 32'd0);
    chk("abort mem_read", 32'(mem_read), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("post-reset mem_read", 32'(mem_read), 32'd1);
    chk("post-reset state", 32'(state_o), 32'd0);
    exp_cnt = 0;
    run(6'b000000, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
